// File: rtl/mem_write_buffer_if.sv
// rtl/mem_write_buffer_if.sv - cache-side and memory-side bus bundle for mem_write_buffer
// slave is the buffer's view; master is the cache + memory environment driving it.
interface mem_write_buffer_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_BITS = 256,
  parameter int DEPTH      = 4
);
  logic                    c_req;
  logic                    c_rw;
  logic [ADDR_WIDTH-1:0]   c_addr;
  logic [BLOCK_BITS-1:0]   c_wdata;
  logic                    c_ready;
  logic                    c_resp;
  logic [BLOCK_BITS-1:0]   c_rdata;

  logic                    mem_req;
  logic                    mem_rw;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [BLOCK_BITS-1:0]   mem_wdata;
  logic                    mem_ready;
  logic                    mem_resp;
  logic [BLOCK_BITS-1:0]   mem_rdata;

  logic [$clog2(DEPTH):0]  buf_count;
  logic                    buf_empty;

  modport slave (
    input  c_req, c_rw, c_addr, c_wdata, mem_ready, mem_resp, mem_rdata,
    output c_ready, c_resp, c_rdata, mem_req, mem_rw, mem_addr, mem_wdata,
           buf_count, buf_empty
  );

  modport master (
    output c_req, c_rw, c_addr, c_wdata, mem_ready, mem_resp, mem_rdata,
    input  c_ready, c_resp, c_rdata, mem_req, mem_rw, mem_addr, mem_wdata,
           buf_count, buf_empty
  );
endinterface

// File: rtl/mem_write_buffer.sv
// rtl/mem_write_buffer.sv - coalescing writeback buffer between a block cache and main memory
// Reads hit buffered blocks first; buffered blocks drain in FIFO order whenever the cache is quiet.
module mem_write_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int BLOCK_BITS = 256,
  parameter int DEPTH      = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_write_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = ADDR_WIDTH - 5;

  typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_WR_WAIT} state_t;

  state_t                state_q, state_d;
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic [TW-1:0]         tag_q  [DEPTH];
  logic [TW-1:0]         tag_d  [DEPTH];
  logic [BLOCK_BITS-1:0] data_q [DEPTH];
  logic [BLOCK_BITS-1:0] data_d [DEPTH];
  logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  rd_pend_q, rd_pend_d;
  logic                  mem_req_q, mem_req_d, mem_rw_q, mem_rw_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BLOCK_BITS-1:0] mem_wdata_q, mem_wdata_d;
  logic                  c_resp_q, c_resp_d;
  logic [BLOCK_BITS-1:0] c_rdata_q, c_rdata_d;

  logic [TW-1:0]         req_tag;
  logic                  c_ready, accept, hit;
  logic [PW-1:0]         hit_idx;
  logic                  unused_offset;

  assign req_tag       = bus.c_addr[ADDR_WIDTH-1:5];
  assign unused_offset = ^bus.c_addr[4:0];
  assign c_ready       = (state_q == S_IDLE) && (count_q < CW'(DEPTH));
  assign accept        = bus.c_req && c_ready;

  // Coalescing keeps every tag unique, so at most one entry can match.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = PW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    rd_pend_d   = rd_pend_q;
    mem_req_d   = 1'b0;
    mem_rw_d    = mem_rw_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    c_resp_d    = 1'b0;
    c_rdata_d   = c_rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept && bus.c_rw) begin
          c_resp_d = 1'b1;
          if (hit) begin
            data_d[hit_idx] = bus.c_wdata;
          end else begin
            valid_d[tail_q] = 1'b1;
            tag_d[tail_q]   = req_tag;
            data_d[tail_q]  = bus.c_wdata;
            tail_d          = tail_q + PW'(1);
            count_d         = count_q + CW'(1);
          end
        end else if (accept && hit) begin
          c_rdata_d = data_q[hit_idx];
          c_resp_d  = 1'b1;
        end else if (accept) begin
          // A refill accepted while memory is busy waits in S_RD_WAIT until mem_ready.
          mem_rw_d   = 1'b0;
          mem_addr_d = {req_tag, 5'b0};
          mem_req_d  = bus.mem_ready;
          rd_pend_d  = !bus.mem_ready;
          state_d    = S_RD_WAIT;
        end else if ((count_q != '0) && bus.mem_ready) begin
          mem_req_d   = 1'b1;
          mem_rw_d    = 1'b1;
          mem_addr_d  = {tag_q[head_q], 5'b0};
          mem_wdata_d = data_q[head_q];
          state_d     = S_WR_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (rd_pend_q) begin
          if (bus.mem_ready) begin
            mem_req_d = 1'b1;
            rd_pend_d = 1'b0;
          end
        end else if (bus.mem_resp) begin
          c_rdata_d = bus.mem_rdata;
          c_resp_d  = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WR_WAIT: begin
        if (bus.mem_resp) begin
          valid_d[head_q] = 1'b0;
          head_d          = head_q + PW'(1);
          count_d         = count_q - CW'(1);
          state_d         = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      tag_q       <= '{default: '0};
      data_q      <= '{default: '0};
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rd_pend_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      c_resp_q    <= 1'b0;
      c_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      rd_pend_q   <= rd_pend_d;
      mem_req_q   <= mem_req_d;
      mem_rw_q    <= mem_rw_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      c_resp_q    <= c_resp_d;
      c_rdata_q   <= c_rdata_d;
    end
  end

  assign bus.c_ready   = c_ready;
  assign bus.c_resp    = c_resp_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_rw    = mem_rw_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.buf_count = count_q;
  assign bus.buf_empty = (count_q == '0);
endmodule

// File: tb/tb_mem_write_buffer.sv
// tb/tb_mem_write_buffer.sv - self-checking bench for mem_write_buffer
// Model: a FIFO queue of buffered blocks plus a sparse memory image; memory agent answers requests.
`timescale 1ns/1ps
module tb_mem_write_buffer;
  localparam int AW    = 32;
  localparam int BB    = 256;
  localparam int DEPTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_write_buffer_if #(.ADDR_WIDTH(AW), .BLOCK_BITS(BB), .DEPTH(DEPTH)) bus ();

  mem_write_buffer #(.ADDR_WIDTH(AW), .BLOCK_BITS(BB), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [BB-1:0] data;
  } ent_t;

  ent_t          mq[$];
  logic [BB-1:0] store[logic [AW-1:0]];
  logic [AW:0]   req_log[$];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  bit            rnd_ready = 0, chk_stable = 1, fix_lat = 0;
  int            lat_val = 1;
  bit            out_busy = 0, resp_active = 0, out_rw = 0, drain_inflight = 0;
  logic [AW-1:0] out_addr, last_rd_addr;
  logic [BB-1:0] out_data;
  int            out_lat = 0, resp_cycle = -1, rd_cnt = 0, wr_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [BB-1:0] got, input logic [BB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] blk(input logic [AW-1:0] a);
    return {a[AW-1:5], 5'b0};
  endfunction

  function automatic logic [BB-1:0] mem_block(input logic [AW-1:0] a);
    logic [BB-1:0] b;
    logic [AW-1:0] base;
    base = blk(a);
    if (store.exists(base)) return store[base];
    for (int i = 0; i < BB / 32; i++) b[32*i +: 32] = base + 32'(4 * i);
    return b;
  endfunction

  function automatic logic [BB-1:0] rnd_blk();
    logic [BB-1:0] b;
    for (int i = 0; i < BB / 32; i++) b[32*i +: 32] = $urandom;
    return b;
  endfunction

  function automatic int mfind(input logic [AW-1:0] a);
    for (int i = 0; i < mq.size(); i++) if (mq[i].addr == blk(a)) return i;
    return -1;
  endfunction

  // Memory agent: works 1ns after each edge, the cache side works 3ns after.
  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (resp_active) begin
        bus.mem_resp = 1'b0;
        resp_active  = 0;
        out_busy     = 0;
        if (out_rw) begin
          store[out_addr] = out_data;
          if (mq.size() > 0) void'(mq.pop_front());
          drain_inflight = 0;
        end
      end
      if (bus.mem_req === 1'b1) begin
        check("mem_ready_at_req", bus.mem_ready, 1);
        check("one_outstanding", out_busy, 0);
        out_busy = 1;
        out_rw   = bus.mem_rw;
        out_addr = bus.mem_addr;
        out_data = bus.mem_wdata;
        out_lat  = fix_lat ? lat_val : $urandom_range(1, 3);
        req_log.push_back({bus.mem_rw, bus.mem_addr});
        if (bus.mem_rw) begin
          wr_cnt++;
          drain_inflight = 1;
          if (mq.size() == 0) check("drain_unexpected", 1, 0);
          else begin
            check("drain_addr", bus.mem_addr, mq[0].addr);
            check("drain_data", bus.mem_wdata, mq[0].data);
          end
        end else begin
          rd_cnt++;
          last_rd_addr = bus.mem_addr;
        end
      end else if (out_busy) begin
        if (chk_stable) begin
          check("mem_addr_stable", bus.mem_addr, out_addr);
          check("mem_rw_stable", bus.mem_rw, out_rw);
          if (out_rw) check("mem_wdata_stable", bus.mem_wdata, out_data);
        end
        out_lat--;
        if (out_lat <= 0) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = out_rw ? rnd_blk() : mem_block(out_addr);
          resp_active   = 1;
          resp_cycle    = cyc + 1;
        end
      end
      if (rnd_ready) bus.mem_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic do_req(input bit rw, input logic [AW-1:0] addr, input logic [BB-1:0] wdata);
    bit            acc;
    bit            exp_rdy;
    int            idx, rd0;
    logic [BB-1:0] exp;
    acc = 0;
    rd0 = rd_cnt;
    bus.c_req   = 1'b1;
    bus.c_rw    = rw;
    bus.c_addr  = addr;
    bus.c_wdata = wdata;
    for (int k = 0; k < 300 && !acc; k++) begin
      exp_rdy = !drain_inflight && (mq.size() < DEPTH);
      check("c_ready", bus.c_ready, exp_rdy);
      acc = (bus.c_ready === 1'b1);
      rd0 = rd_cnt;
      @(posedge clk); #3;
    end
    bus.c_req = 1'b0;
    if (!acc) begin
      check("accept_timeout", 0, 1);
      return;
    end
    idx = mfind(addr);
    if (rw) begin
      check("wr_resp", bus.c_resp, 1);
      if (idx >= 0) mq[idx].data = wdata;
      else mq.push_back('{blk(addr), wdata});
      check("buf_count_wr", bus.buf_count, mq.size());
    end else if (idx >= 0) begin
      check("rd_hit_resp", bus.c_resp, 1);
      check("rd_hit_data", bus.c_rdata, mq[idx].data);
      check("rd_hit_no_mem", rd_cnt, rd0);
    end else begin
      exp = mem_block(addr);
      check("rd_miss_early_resp", bus.c_resp, 0);
      for (int k = 0; k < 200 && bus.c_resp !== 1'b1; k++) begin
        @(posedge clk); #3;
      end
      if (bus.c_resp !== 1'b1) check("rd_miss_timeout", 0, 1);
      else begin
        check("rd_miss_resp_cycle", cyc, resp_cycle);
        check("rd_miss_data", bus.c_rdata, exp);
        check("rd_miss_one_req", rd_cnt, rd0 + 1);
        check("rd_miss_addr", last_rd_addr, blk(addr));
      end
    end
  endtask

  task automatic wait_empty();
    rnd_ready     = 0;
    bus.mem_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (bus.buf_count == 0 && !drain_inflight && !out_busy) break;
      @(posedge clk); #3;
    end
    check("drain_to_empty", bus.buf_count, 0);
    check("buf_empty", bus.buf_empty, 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_c_ready"}, bus.c_ready, 1);
    check({tag, "_buf_empty"}, bus.buf_empty, 1);
    check({tag, "_buf_count"}, bus.buf_count, 0);
    check({tag, "_c_resp"}, bus.c_resp, 0);
    check({tag, "_c_rdata"}, bus.c_rdata, 0);
    check({tag, "_mem_req"}, bus.mem_req, 0);
    check({tag, "_mem_rw"}, bus.mem_rw, 0);
    check({tag, "_mem_addr"}, bus.mem_addr, 0);
    check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [BB-1:0] a_blk, b_blk;
    logic [AW-1:0] addr;
    int            r0, w0;
    bit            seen;
    bus.c_req   = 1'b0;
    bus.c_rw    = 1'b0;
    bus.c_addr  = '0;
    bus.c_wdata = '0;
    repeat (3) @(posedge clk);
    #3;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #3;

    // Write then hit-read of the same block at a different offset.
    a_blk = rnd_blk();
    do_req(1, 32'h100, a_blk);
    do_req(0, 32'h11C, '0);
    check("t1_count", bus.buf_count, 1);
    check("t1_no_mem", rd_cnt + wr_cnt, 0);
    wait_empty();

    // Refill from an untouched block: words equal their byte addresses.
    do_req(0, 32'h200, '0);
    check("t2_word0", bus.c_rdata[31:0], 32'h200);
    check("t2_word7", bus.c_rdata[255:224], 32'h21C);

    // Coalescing: second write replaces the first in place.
    bus.mem_ready = 1'b0;
    w0 = wr_cnt;
    a_blk = rnd_blk();
    b_blk = rnd_blk();
    do_req(1, 32'h100, a_blk);
    do_req(1, 32'h100, b_blk);
    check("t3_count", bus.buf_count, 1);
    wait_empty();
    check("t3_one_drain", wr_cnt - w0, 1);
    do_req(0, 32'h100, '0);
    check("t3_readback", bus.c_rdata, b_blk);

    // Fill to DEPTH, then drain in FIFO order.
    bus.mem_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) do_req(1, 32'(i * 32), rnd_blk());
    check("t4_full_ready", bus.c_ready, 0);
    check("t4_full_count", bus.buf_count, DEPTH);
    check("t4_not_empty", bus.buf_empty, 0);
    req_log.delete();
    wait_empty();
    check("t4_drains", req_log.size(), DEPTH);
    for (int i = 0; i < DEPTH && i < req_log.size(); i++)
      check("t4_drain_order", req_log[i], {1'b1, 32'(i * 32)});

    // Read and drain eligible on the same edge: read goes first.
    bus.mem_ready = 1'b0;
    do_req(1, 32'h400, rnd_blk());
    req_log.delete();
    bus.mem_ready = 1'b1;
    do_req(0, 32'h300, '0);
    wait_empty();
    check("t5_reqs", req_log.size(), 2);
    if (req_log.size() >= 2) begin
      check("t5_first_read", req_log[0], {1'b0, 32'h300});
      check("t5_then_drain", req_log[1], {1'b1, 32'h400});
    end

    // Reset while a refill is outstanding.
    fix_lat = 1;
    lat_val = 8;
    r0 = rd_cnt;
    bus.c_req  = 1'b1;
    bus.c_rw   = 1'b0;
    bus.c_addr = 32'h500;
    check("t6_ready", bus.c_ready, 1);
    @(posedge clk); #3;
    bus.c_req = 1'b0;
    repeat (2) begin
      @(posedge clk); #3;
    end
    check("t6_req_sent", rd_cnt, r0 + 1);
    chk_stable = 0;
    rst_n = 1'b0;
    #1;
    check_reset_vals("t6");
    mq.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      if (bus.c_resp === 1'b1) seen = 1;
      @(posedge clk); #3;
    end
    check("t6_no_late_resp", seen, 0);
    check("t6_late_resp_done", out_busy, 0);
    check("t6_ready_after", bus.c_ready, 1);
    chk_stable = 1;
    fix_lat    = 0;

    // Randomized traffic over a small set of blocks so hits and coalescing are common.
    rnd_ready = 1;
    for (int n = 0; n < 200; n++) begin
      addr = 32'($urandom_range(0, 7)) * 32 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) do_req(1, addr, rnd_blk());
      else do_req(0, addr, '0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #3;
      end
    end
    wait_empty();
    for (int i = 0; i < 8; i++) do_req(0, 32'(i * 32), '0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
